// File: rtl/fsm_key_loader.sv
// Serial obfuscation-key loader: shifts a key LSB-first, validates it on commit and
// enforces a per-reset load budget. Define FSM_KEY_LOADER_PARITY_EN to require a trailing even-parity bit.
module fsm_key_loader #(
    parameter int unsigned KEY_W     = 8,
    parameter int unsigned MAX_LOADS = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             key_sdi,
    input  logic                             key_sen,
    input  logic                             key_commit,
    input  logic                             key_clear,
    output logic [KEY_W-1:0]                 key_out,
    output logic                             key_valid,
    output logic                             key_err,
    output logic                             locked,
    output logic [$clog2(MAX_LOADS+1)-1:0]   load_cnt
);

    localparam int unsigned LC_W     = $clog2(MAX_LOADS + 1);
`ifdef FSM_KEY_LOADER_PARITY_EN
    localparam int unsigned CNT_MAX  = KEY_W + 2;
    localparam int unsigned CNT_GOOD = KEY_W + 1;
`else
    localparam int unsigned CNT_MAX  = KEY_W + 1;
    localparam int unsigned CNT_GOOD = KEY_W;
`endif
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [KEY_W-1:0]   key_out_d;
    logic               key_valid_d;
    logic               key_err_d;
    logic               locked_d;
    logic [LC_W-1:0]    load_cnt_d;
    logic [LC_W-1:0]    load_cnt_inc;
    logic               commit_ok;
`ifdef FSM_KEY_LOADER_PARITY_EN
    logic               par_q, par_d;
`endif

    // A commit is good only with exactly the expected number of shifted bits.
    always_comb begin
`ifdef FSM_KEY_LOADER_PARITY_EN
        commit_ok = (bit_cnt_q == CNT_W'(CNT_GOOD)) && ((^shadow_q ^ par_q) == 1'b0);
`else
        commit_ok = (bit_cnt_q == CNT_W'(CNT_GOOD));
`endif
    end

    assign load_cnt_inc = load_cnt + LC_W'(1);

    // Next-state and registered-output logic; priority is clear > commit > shift.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        bit_cnt_d   = bit_cnt_q;
        key_out_d   = key_out;
        key_valid_d = key_valid;
        key_err_d   = 1'b0;
        locked_d    = locked;
        load_cnt_d  = load_cnt;
`ifdef FSM_KEY_LOADER_PARITY_EN
        par_d       = par_q;
`endif
        unique case (state_q)
            IDLE, SHIFT: begin
                if (key_clear) begin
                    shadow_d  = '0;
                    bit_cnt_d = '0;
`ifdef FSM_KEY_LOADER_PARITY_EN
                    par_d     = 1'b0;
`endif
                    state_d   = IDLE;
                end else if (key_commit) begin
                    load_cnt_d = load_cnt_inc;
                    if (commit_ok) begin
                        key_out_d   = shadow_q;
                        key_valid_d = 1'b1;
                    end else begin
                        key_err_d   = 1'b1;
                    end
                    shadow_d  = '0;
                    bit_cnt_d = '0;
`ifdef FSM_KEY_LOADER_PARITY_EN
                    par_d     = 1'b0;
`endif
                    if (load_cnt_inc == LC_W'(MAX_LOADS)) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end else begin
                        state_d  = IDLE;
                    end
                end else if (key_sen) begin
`ifdef FSM_KEY_LOADER_PARITY_EN
                    if (bit_cnt_q < CNT_W'(KEY_W)) begin
                        shadow_d = {key_sdi, shadow_q[KEY_W-1:1]};
                    end else begin
                        par_d    = key_sdi;
                    end
`else
                    shadow_d = {key_sdi, shadow_q[KEY_W-1:1]};
`endif
                    if (bit_cnt_q != CNT_W'(CNT_MAX)) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                    state_d = SHIFT;
                end
            end
            LOCKED: begin
                state_d = LOCKED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            bit_cnt_q <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            key_err   <= 1'b0;
            locked    <= 1'b0;
            load_cnt  <= '0;
`ifdef FSM_KEY_LOADER_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            bit_cnt_q <= bit_cnt_d;
            key_out   <= key_out_d;
            key_valid <= key_valid_d;
            key_err   <= key_err_d;
            locked    <= locked_d;
            load_cnt  <= load_cnt_d;
`ifdef FSM_KEY_LOADER_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_fsm_key_loader.sv
// Scoreboard bench for fsm_key_loader: a queue-based key model predicts every cycle's outputs.
module tb_fsm_key_loader;

    localparam int unsigned KEY_W     = 8;
    localparam int unsigned MAX_LOADS = 3;
`ifdef FSM_KEY_LOADER_PARITY_EN
    localparam int unsigned KN = KEY_W + 1;
`else
    localparam int unsigned KN = KEY_W;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             key_sdi = 1'b0;
    logic             key_sen = 1'b0;
    logic             key_commit = 1'b0;
    logic             key_clear = 1'b0;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             key_err;
    logic             locked;
    logic [1:0]       load_cnt;

    fsm_key_loader #(.KEY_W(KEY_W), .MAX_LOADS(MAX_LOADS)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_sdi    (key_sdi),
        .key_sen    (key_sen),
        .key_commit (key_commit),
        .key_clear  (key_clear),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .key_err    (key_err),
        .locked     (locked),
        .load_cnt   (load_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic             valid;
        logic             err;
        logic             lock;
        logic [1:0]       cnt;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: the list of bits received since the last commit/clear.
    bit               m_bits[$];
    logic [KEY_W-1:0] m_key;
    bit               m_valid;
    bit               m_lock;
    int               m_cnt;

    function automatic bit model_good();
        bit x;
        x = 1'b0;
`ifdef FSM_KEY_LOADER_PARITY_EN
        if (m_bits.size() != KEY_W + 1) return 1'b0;
        foreach (m_bits[i]) x ^= m_bits[i];
        return (x == 1'b0);
`else
        return (m_bits.size() == KEY_W);
`endif
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_key   = '0;
        m_valid = 1'b0;
        m_lock  = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic cycle(input bit sen, input bit sdi, input bit commit, input bit clear);
        obs_t e;
        bit   err;
        @(negedge clk);
        key_sen    = sen;
        key_sdi    = sdi;
        key_commit = commit;
        key_clear  = clear;
        err = 1'b0;
        if (!m_lock) begin
            if (clear) begin
                m_bits.delete();
            end else if (commit) begin
                m_cnt++;
                if (model_good()) begin
                    for (int i = 0; i < KEY_W; i++) m_key[i] = m_bits[i];
                    m_valid = 1'b1;
                end else begin
                    err = 1'b1;
                end
                m_bits.delete();
                if (m_cnt == MAX_LOADS) m_lock = 1'b1;
            end else if (sen) begin
                m_bits.push_back(sdi);
            end
        end
        e.key   = m_key;
        e.valid = m_valid;
        e.err   = err;
        e.lock  = m_lock;
        e.cnt   = 2'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic shift_bits(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, v[i], 1'b0, 1'b0);
    endtask

    function automatic logic [15:0] frame(input logic [KEY_W-1:0] k);
        logic [15:0] f;
        f = 16'(k);
`ifdef FSM_KEY_LOADER_PARITY_EN
        f[KEY_W] = ^k;
`endif
        return f;
    endfunction

    // Asynchronous reset mid low-phase; outputs must clear without a clock edge.
    task automatic do_reset();
        obs_t a;
        @(negedge clk);
        key_sen = 1'b0; key_sdi = 1'b0; key_commit = 1'b0; key_clear = 1'b0;
        #2 rst = 1'b0;
        #1;
        a = {key_out, key_valid, key_err, locked, load_cnt};
        checks++;
        if (a !== '0) begin
            failures++;
            $display("FAIL reset_state actual=%h required=0", a);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // Monitor: compares DUT outputs to the oldest pending prediction after each edge.
    obs_t mon_e, mon_a;
    always @(posedge clk) begin
        #1;
        if (rst && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {key_out, key_valid, key_err, locked, load_cnt};
            checks++;
            if (mon_a !== mon_e) begin
                failures++;
                $display("FAIL scoreboard t=%0t key_out=%h/%h valid=%b/%b err=%b/%b locked=%b/%b load_cnt=%0d/%0d (actual/required)",
                         $time, mon_a.key, mon_e.key, mon_a.valid, mon_e.valid, mon_a.err, mon_e.err,
                         mon_a.lock, mon_e.lock, mon_a.cnt, mon_e.cnt);
            end
        end
    end

    initial begin
        logic [15:0] fr;
        int          r;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_reset();

        // Known key 1,0,1,1,0,0,1,0 -> 8'h4D, then short load, then lockout.
        shift_bits(frame(8'h4D), KN);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        shift_bits(16'h0015, 5);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle(); idle();
        shift_bits(16'h0005, 3);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        shift_bits(frame(8'hA5), KN);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        idle();

        // Coincident inputs.
        do_reset();
        shift_bits(frame(8'h3C), KN);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        idle();
        shift_bits(frame(8'h96), KN);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        idle();

        // Reset in the middle of a shift.
        do_reset();
        shift_bits(16'h000F, 4);
        do_reset();
        shift_bits(frame(8'hE7), KN);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle();

`ifdef FSM_KEY_LOADER_PARITY_EN
        do_reset();
        shift_bits({7'd0, 1'b0, 8'h4D}, 9);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        shift_bits({7'd0, 1'b1, 8'h4D}, 9);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        shift_bits(16'h004D, 8);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle();
`endif

        // Randomized episodes.
        for (int ep = 0; ep < 15; ep++) begin
            do_reset();
            for (int op = 0; op < 30; op++) begin
                r = int'($urandom_range(0, 9));
                case (r)
                    0, 1: begin
                        fr = frame(KEY_W'($urandom));
                        if ($urandom_range(0, 3) == 0) fr[$urandom_range(0, KN - 1)] ^= 1'b1;
                        shift_bits(fr, KN);
                        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
                    end
                    2: cycle(1'b0, 1'b0, 1'b1, 1'b0);
                    3: cycle(1'b0, 1'b0, 1'b0, 1'b1);
                    4: cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
                    5: begin
                        shift_bits(16'($urandom), KN + 1 + int'($urandom_range(0, 2)));
                        cycle(1'b0, 1'b0, 1'b1, 1'b0);
                    end
                    default: cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
                endcase
            end
            idle();
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
